// File: rtl/sdram_wb_arbiter.sv
// N-channel Wishbone arbiter in front of the SDRAM controller port.
// Round-robin or fixed-priority grant, burst-capped hold, per-beat ack timeout with error return.
module sdram_wb_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int WB_ADDR_WIDTH  = 24,
  parameter int WB_DATA_WIDTH  = 16,
  parameter int ARB_MODE       = 0,
  parameter int MAX_BURST      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                 wb_clk_i,
  input  logic                                 wb_rst_ni,
  input  logic [NUM_CH-1:0]                    m_cyc_i,
  input  logic [NUM_CH-1:0]                    m_stb_i,
  input  logic [NUM_CH-1:0]                    m_we_i,
  input  logic [NUM_CH*WB_ADDR_WIDTH-1:0]      m_adr_i,
  input  logic [NUM_CH*WB_DATA_WIDTH-1:0]      m_dat_i,
  input  logic [NUM_CH*WB_DATA_WIDTH/8-1:0]    m_sel_i,
  output logic [NUM_CH-1:0]                    m_ack_o,
  output logic [NUM_CH-1:0]                    m_err_o,
  output logic [WB_DATA_WIDTH-1:0]             m_dat_o,
  output logic                                 s_cyc_o,
  output logic                                 s_stb_o,
  output logic                                 s_we_o,
  output logic [WB_ADDR_WIDTH-1:0]             s_adr_o,
  output logic [WB_DATA_WIDTH-1:0]             s_dat_o,
  output logic [WB_DATA_WIDTH/8-1:0]           s_sel_o,
  input  logic                                 s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0]             s_dat_i,
  output logic [NUM_CH-1:0]                    grant_o
);
  localparam int SW = WB_DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_CH);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]                             state;
  logic [IW-1:0]                          gidx, rr_ptr, win, jdx;
  logic [BW-1:0]                          burst_cnt;
  logic [TW-1:0]                          tmo_cnt;
  logic [NUM_CH-1:0]                      req;
  logic                                   found, busy, cyc_g, stb_g, ack_g, tmo_hit, last_beat;
  logic [NUM_CH-1:0][WB_ADDR_WIDTH-1:0]   adr_v;
  logic [NUM_CH-1:0][WB_DATA_WIDTH-1:0]   dat_v;
  logic [NUM_CH-1:0][SW-1:0]              sel_v;

  assign adr_v = m_adr_i;
  assign dat_v = m_dat_i;
  assign sel_v = m_sel_i;
  assign req   = m_cyc_i & m_stb_i;

  always_comb begin
    win   = '0;
    jdx   = '0;
    found = 1'b0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (req[i]) win = IW'(i);
    end else begin
      // scan upward from the slot after the last winner, wrapping
      for (int i = 1; i <= NUM_CH; i++) begin
        jdx = IW'((int'(rr_ptr) + i) % NUM_CH);
        if (!found && req[jdx]) begin
          found = 1'b1;
          win   = jdx;
        end
      end
    end
  end

  assign busy      = (state == BUSY);
  assign cyc_g     = busy & m_cyc_i[gidx];
  assign stb_g     = cyc_g & m_stb_i[gidx];
  assign ack_g     = cyc_g & s_ack_i;
  assign last_beat = (burst_cnt == BW'(MAX_BURST - 1));
  // an ack in the final timeout cycle still wins
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && stb_g && !s_ack_i &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign s_cyc_o = cyc_g & ~tmo_hit;
  assign s_stb_o = stb_g & ~tmo_hit;
  assign s_we_o  = busy & m_we_i[gidx];
  assign s_adr_o = busy ? adr_v[gidx] : '0;
  assign s_dat_o = busy ? dat_v[gidx] : '0;
  assign s_sel_o = busy ? sel_v[gidx] : '0;
  assign m_ack_o = ack_g   ? grant_o : '0;
  assign m_err_o = tmo_hit ? grant_o : '0;
  assign m_dat_o = s_dat_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      grant_o   <= '0;
      gidx      <= '0;
      rr_ptr    <= IW'(NUM_CH - 1);
      burst_cnt <= '0;
      tmo_cnt   <= '0;
    end else if (state == IDLE) begin
      burst_cnt <= '0;
      tmo_cnt   <= '0;
      if (|req) begin
        state   <= BUSY;
        gidx    <= win;
        rr_ptr  <= win;
        grant_o <= {{(NUM_CH-1){1'b0}}, 1'b1} << win;
      end
    end else begin
      if (!cyc_g || tmo_hit || (ack_g && last_beat)) begin
        state     <= IDLE;
        grant_o   <= '0;
        burst_cnt <= '0;
        tmo_cnt   <= '0;
      end else if (ack_g) begin
        burst_cnt <= burst_cnt + 1'b1;
        tmo_cnt   <= '0;
      end else if (stb_g && TIMEOUT_CYCLES != 0) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
endmodule
